// File: rtl/fp_normalize_round_if.sv
// fp_normalize_round_if: handshake and data bundle for the normalise/round/pack stage.
// The master side feeds adder beats in and consumes packed results.
// The slave side is the fp_normalize_round block itself.
interface fp_normalize_round_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    // Upstream beat from the mantissa adder
    logic                   in_valid;
    logic                   in_ready;
    logic [MAN_W+1:0]       sum_man;
    logic                   sum_sign;
    logic [EXP_W-1:0]       sum_exp;
    logic [2:0]             sum_grs;

    // Downstream packed result
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   result;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output in_valid,
        output sum_man,
        output sum_sign,
        output sum_exp,
        output sum_grs,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  in_valid,
        input  sum_man,
        input  sum_sign,
        input  sum_exp,
        input  sum_grs,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: final stage of the binary32 add/sub pipeline.
// Normalises the raw adder magnitude (carry shift or leading-zero shift),
// rounds, and packs {sign, exp, frac}. Two register stages (N = normalise,
// R = round/pack) joined by a valid/ready handshake with no bubble when full.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even;
// when undefined the block truncates (round toward zero).
module fp_normalize_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_normalize_round_if.slave  bus
);

    // Mantissa including hidden bit, raw sum width with carry, internal signed exponent
    localparam int MNT_W = MAN_W + 1;
    localparam int SUM_W = MAN_W + 2;
    localparam int E_W   = EXP_W + 2;
    localparam int LZ_W  = $clog2(MNT_W);

    localparam logic signed [E_W-1:0] EXP_ONE_S = E_W'(1);
    localparam logic signed [E_W-1:0] EXP_MAX_S = E_W'((2 ** EXP_W) - 1);

`ifdef FP_ROUND_NEAREST_EN
    localparam logic ROUND_RNE = 1'b1;
`else
    localparam logic ROUND_RNE = 1'b0;
`endif

    // Leading zeros of the 24-bit mantissa; an all-zero input reports MNT_W-1
    function automatic logic [LZ_W-1:0] count_lz(input logic [MNT_W-1:0] m);
        logic [LZ_W-1:0] lz;
        lz = LZ_W'(MNT_W - 1);
        for (int i = 0; i < MNT_W; i++) begin
            if (m[i]) begin
                lz = LZ_W'(MNT_W - 1 - i);
            end else begin
                lz = lz;
            end
        end
        return lz;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic adv_r_s;
    logic adv_n_s;

    logic out_valid_q;
    logic n_valid_q;

    assign adv_r_s      = !out_valid_q || bus.out_ready;
    assign adv_n_s      = !n_valid_q || adv_r_s;
    assign bus.in_ready = adv_n_s;

    // ------------------------------------------------------------------
    // Stage N: normalise
    // ------------------------------------------------------------------
    logic signed [E_W-1:0]   exp_ext_s;
    logic [LZ_W-1:0]         lz_s;
    logic [MNT_W+1:0]        shift_s;

    logic [MNT_W-1:0]        n_man_d,   n_man_q;
    logic signed [E_W-1:0]   n_exp_d,   n_exp_q;
    logic                    n_sign_d,  n_sign_q;
    logic                    n_g_d,     n_g_q;
    logic                    n_r_d,     n_r_q;
    logic                    n_s_d,     n_s_q;
    logic                    n_flush_d, n_flush_q;
    logic                    n_uf_d,    n_uf_q;

    assign exp_ext_s = $signed({{(E_W-EXP_W){1'b0}}, bus.sum_exp});

    // Carry right-shift, exact-zero detection or leading-zero left-shift with underflow flush
    always_comb begin
        lz_s      = count_lz(bus.sum_man[MNT_W-1:0]);
        shift_s   = '0;
        n_man_d   = '0;
        n_exp_d   = exp_ext_s;
        n_sign_d  = bus.sum_sign;
        n_g_d     = 1'b0;
        n_r_d     = 1'b0;
        n_s_d     = 1'b0;
        n_flush_d = 1'b0;
        n_uf_d    = 1'b0;
        if (bus.sum_man[SUM_W-1]) begin
            // Carry out of the adder: one place right, old G becomes R, R|S collapses into S
            n_man_d = bus.sum_man[SUM_W-1:1];
            n_g_d   = bus.sum_man[0];
            n_r_d   = bus.sum_grs[2];
            n_s_d   = bus.sum_grs[1] | bus.sum_grs[0];
            n_exp_d = exp_ext_s + EXP_ONE_S;
        end else if ((bus.sum_man == {SUM_W{1'b0}}) && (bus.sum_grs == 3'b000)) begin
            // Exact cancellation always yields +0
            n_sign_d  = 1'b0;
            n_flush_d = 1'b1;
        end else begin
            // G and R shift in behind the mantissa; sticky stays where it is
            shift_s = {bus.sum_man[MNT_W-1:0], bus.sum_grs[2], bus.sum_grs[1]} << lz_s;
            n_man_d = shift_s[MNT_W+1:2];
            n_g_d   = shift_s[1];
            n_r_d   = shift_s[0];
            n_s_d   = bus.sum_grs[0];
            n_exp_d = exp_ext_s - $signed({{(E_W-LZ_W){1'b0}}, lz_s});
            if (n_exp_d < EXP_ONE_S) begin
                // No subnormals: flush to signed zero and skip rounding
                n_flush_d = 1'b1;
                n_uf_d    = 1'b1;
            end else begin
                n_flush_d = 1'b0;
                n_uf_d    = 1'b0;
            end
        end
    end

    // Stage N register: loads whenever the stage is free or draining this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_valid_q <= 1'b0;
            n_man_q   <= '0;
            n_exp_q   <= '0;
            n_sign_q  <= 1'b0;
            n_g_q     <= 1'b0;
            n_r_q     <= 1'b0;
            n_s_q     <= 1'b0;
            n_flush_q <= 1'b0;
            n_uf_q    <= 1'b0;
        end else if (adv_n_s) begin
            n_valid_q <= bus.in_valid;
            n_man_q   <= n_man_d;
            n_exp_q   <= n_exp_d;
            n_sign_q  <= n_sign_d;
            n_g_q     <= n_g_d;
            n_r_q     <= n_r_d;
            n_s_q     <= n_s_d;
            n_flush_q <= n_flush_d;
            n_uf_q    <= n_uf_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage R: round and pack
    // ------------------------------------------------------------------
    logic                    inc_s;
    logic [MNT_W:0]          rnd_sum_s;
    logic [MNT_W-1:0]        r_man_s;
    logic signed [E_W-1:0]   r_exp_s;

    logic [EXP_W+MAN_W:0]    result_d,    result_q;
    logic                    overflow_d,  overflow_q;
    logic                    underflow_d, underflow_q;

    // Round increment, mantissa carry renormalisation, saturation and flush packing
    always_comb begin
        inc_s       = ROUND_RNE & n_g_q & (n_r_q | n_s_q | n_man_q[0]);
        rnd_sum_s   = {1'b0, n_man_q} + {{MNT_W{1'b0}}, inc_s};
        r_man_s     = rnd_sum_s[MNT_W-1:0];
        r_exp_s     = n_exp_q;
        result_d    = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (rnd_sum_s[MNT_W]) begin
            // Rounding rolled over to 10.000...: back to 1.000... one binade up
            r_man_s = {1'b1, {MAN_W{1'b0}}};
            r_exp_s = n_exp_q + EXP_ONE_S;
        end else begin
            r_man_s = rnd_sum_s[MNT_W-1:0];
            r_exp_s = n_exp_q;
        end
        if (n_flush_q) begin
            result_d    = {n_sign_q, {(EXP_W+MAN_W){1'b0}}};
            underflow_d = n_uf_q;
        end else if (r_exp_s >= EXP_MAX_S) begin
            result_d   = {n_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow_d = 1'b1;
        end else begin
            result_d = {n_sign_q, r_exp_s[EXP_W-1:0], r_man_s[MAN_W-1:0]};
        end
    end

    // Output register: holds while the downstream stalls a valid result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (adv_r_s) begin
            out_valid_q <= n_valid_q;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: scoreboard bench for fp_normalize_round.
// Stimulus pushes the expected {result, overflow, underflow} when a beat is
// accepted; an independent monitor pops and compares on every output transfer.
// Respects FP_ROUND_NEAREST_EN the same way as the design.
module tb_fp_normalize_round;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_normalize_round_if bus_if ();

    fp_normalize_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [33:0] sb_q[$];
    bit          rand_done = 1'b0;

`ifdef FP_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    // Reference: value-level reading of the normalise/round/pack rules.
    // Encoding: [33:2] packed result, [1] overflow, [0] underflow.
    function automatic logic [33:0] ref_model(input logic [24:0] man, input logic sgn,
                                              input logic [7:0] ex, input logic [2:0] grs);
        longint m;
        longint mant;
        longint ext;
        int     e;
        int     lz;
        bit     g, r, s, lsb, inc;
        logic [7:0]  eb;
        logic [22:0] fb;
        m = 0;
        m = man;
        e = int'(ex);
        if (man == 25'd0 && grs == 3'd0) return 34'd0;
        if (m >= 64'd16777216) begin
            mant = m / 2;
            g    = (m % 2) != 0;
            r    = grs[2];
            s    = grs[1] | grs[0];
            e    = e + 1;
        end else begin
            lz = 0;
            while (lz < 23 && ((m >> (23 - lz)) % 2) == 0) lz++;
            ext  = (m * 4) + (grs[2] ? 2 : 0) + (grs[1] ? 1 : 0);
            ext  = ext << lz;
            mant = (ext >> 2) % 64'd16777216;
            g    = ((ext >> 1) % 2) != 0;
            r    = (ext % 2) != 0;
            s    = grs[0];
            e    = e - lz;
            if (e < 1) return {sgn, 31'd0, 2'b01};
        end
        lsb = (mant % 2) != 0;
        inc = RNE && g && (r || s || lsb);
        if (inc) mant = mant + 1;
        if (mant == 64'd16777216) begin
            mant = 64'd8388608;
            e    = e + 1;
        end
        if (e >= 255) return {sgn, 8'hFF, 23'd0, 2'b10};
        eb = 8'(e);
        fb = 23'(mant);
        return {sgn, eb, fb, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Present one beat (called just after a rising edge); push expectation on acceptance
    task automatic send(input logic [24:0] man, input logic sgn, input logic [7:0] ex,
                        input logic [2:0] grs, input logic [33:0] exp_v);
        bit accepted = 1'b0;
        int waited   = 0;
        bus_if.in_valid = 1'b1;
        bus_if.sum_man  = man;
        bus_if.sum_sign = sgn;
        bus_if.sum_exp  = ex;
        bus_if.sum_grs  = grs;
        while (!accepted && waited < 100) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                sb_q.push_back(exp_v);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        bus_if.in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 want acceptance within 100 clk");
        end
    endtask

    // Wait until every expected result has been seen, bounded
    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat(output logic [24:0] man, output logic sgn,
                             output logic [7:0] ex, output logic [2:0] grs);
        int kind;
        kind = int'($urandom_range(0, 9));
        sgn  = 1'($urandom);
        grs  = 3'($urandom);
        ex   = 8'($urandom_range(1, 254));
        case (kind)
            0:       begin man = 25'd0; if ($urandom_range(0, 1) == 0) grs = 3'd0; end
            1, 2:    man = {1'b1, 24'($urandom)};
            3, 4, 5: man = {2'b01, 23'($urandom)};
            6:       begin man = {1'b1, 24'($urandom)}; ex = 8'($urandom_range(250, 254)); end
            7:       begin man = {1'b0, 24'($urandom)} >> $urandom_range(0, 23);
                           ex = 8'($urandom_range(1, 30)); end
            8:       begin man = {2'b00, 23'h7FFFFF}; grs = 3'b1_0_0;
                           ex = 8'($urandom_range(1, 254)); end
            default: man = {1'b0, 24'($urandom)} >> $urandom_range(0, 23);
        endcase
    endtask

    // Monitor: compare on each output transfer, and check a stalled result stays put
    initial begin
        logic [33:0] cur;
        logic [33:0] exp_v;
        logic [33:0] held_val;
        bit          held_v;
        held_v   = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            cur = {bus_if.result, bus_if.overflow, bus_if.underflow};
            if (rst) begin
                held_v = 1'b0;
            end else if (bus_if.out_valid) begin
                if (held_v) begin
                    checks++;
                    if (cur !== held_val) begin
                        errors++;
                        $display("FAIL stall_hold got %h want %h", cur, held_val);
                    end
                end
                if (bus_if.out_ready) begin
                    held_v = 1'b0;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output got %h want no output", cur);
                    end else begin
                        exp_v = sb_q.pop_front();
                        if (cur !== exp_v) begin
                            errors++;
                            $display("FAIL result got res=%h ov=%b uf=%b want res=%h ov=%b uf=%b",
                                     cur[33:2], cur[1], cur[0], exp_v[33:2], exp_v[1], exp_v[0]);
                        end
                    end
                end else begin
                    held_v   = 1'b1;
                    held_val = cur;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        logic [24:0] man;
        logic        sgn;
        logic [7:0]  ex;
        logic [2:0]  grs;

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.sum_man   = 25'd0;
        bus_if.sum_sign  = 1'b0;
        bus_if.sum_exp   = 8'd1;
        bus_if.sum_grs   = 3'd0;
        bus_if.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_result",    64'(bus_if.result),    64'd0);
        chk("rst_flags",     64'({bus_if.overflow, bus_if.underflow}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Carry case with latency observation
        bus_if.in_valid = 1'b1;
        bus_if.sum_man  = 25'h1000000;
        bus_if.sum_sign = 1'b0;
        bus_if.sum_exp  = 8'd127;
        bus_if.sum_grs  = 3'd0;
        @(negedge clk);
        chk("in_ready_idle", 64'(bus_if.in_ready), 64'd1);
        sb_q.push_back({32'h40000000, 2'b00});
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("latency_early", 64'(bus_if.out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("latency_due", 64'(bus_if.out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Directed boundary cases
        send(25'h0000000, 1'b1, 8'd130, 3'b000, {32'h00000000, 2'b00});
        send(25'h0000001, 1'b0, 8'd127, 3'b000, {32'h34000000, 2'b00});
        send(25'h0000001, 1'b0, 8'd20,  3'b000, {32'h00000000, 2'b01});
        send(25'h0000001, 1'b1, 8'd20,  3'b000, {32'h80000000, 2'b01});
        send(25'h1000000, 1'b0, 8'd254, 3'b000, {32'h7F800000, 2'b10});
        send(25'h1000000, 1'b1, 8'd254, 3'b000, {32'hFF800000, 2'b10});
`ifdef FP_ROUND_NEAREST_EN
        send(25'h0FFFFFF, 1'b0, 8'd127, 3'b100, {32'h40000000, 2'b00});
`else
        send(25'h0FFFFFF, 1'b0, 8'd127, 3'b100, {32'h3FFFFFFF, 2'b00});
`endif
        drain();

        // Backpressure: four back-to-back beats against a stalled output
        bus_if.out_ready = 1'b0;
        fork
            begin
                logic [24:0] bm;
                logic        bs;
                logic [7:0]  be;
                logic [2:0]  bg;
                for (int i = 0; i < 4; i++) begin
                    rand_beat(bm, bs, be, bg);
                    send(bm, bs, be, bg, ref_model(bm, bs, be, bg));
                end
            end
            begin
                repeat (3) @(negedge clk);
                chk("in_ready_full",     64'(bus_if.in_ready),  64'd0);
                chk("out_valid_stalled", 64'(bus_if.out_valid), 64'd1);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                bus_if.out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-stream empties the pipe
        rand_beat(man, sgn, ex, grs);
        send(man, sgn, ex, grs, ref_model(man, sgn, ex, grs));
        rand_beat(man, sgn, ex, grs);
        send(man, sgn, ex, grs, ref_model(man, sgn, ex, grs));
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("midrst_result",    64'(bus_if.result),    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_empty", 64'(bus_if.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(25'h0800000, 1'b1, 8'd100, 3'b000, {32'hB2000000, 2'b00});
        drain();

        // Randomised traffic with random gaps and random downstream stalls
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    rand_beat(man, sgn, ex, grs);
                    send(man, sgn, ex, grs, ref_model(man, sgn, ex, grs));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus_if.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus_if.out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
